// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by a small FIFO; frame is start, DATA_BITS LSB-first, optional parity, STOP_BITS stops.
// Build option: UART_TX_FAST_SIM_EN forces one clock per bit.
module uart_tx_fifo #(
  parameter int CLK_FREQ   = 25000000,
  parameter int BAUD       = 115200,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 2,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [DATA_BITS-1:0]          wr_data,
  input  logic                          wr_valid,
  output logic                          wr_ready,
  output logic                          txd,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

`ifdef UART_TX_FAST_SIM_EN
  localparam int DIV = 1;
`else
  localparam int DIV = (CLK_FREQ + BAUD / 2) / BAUD;
`endif
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
  localparam logic [2:0]    BIT_LAST = 3'(DATA_BITS - 1);
  localparam logic          STOP_LAST = 1'(STOP_BITS - 1);
  localparam bit            HAS_PAR = (PARITY == 1) || (PARITY == 2);
  localparam logic          PAR_INV = (PARITY == 2);

  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

  // Handshake: a word transfers on any rising edge where wr_valid && wr_ready.
  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr, rd_ptr;
  logic                 push, pop, fifo_nonempty, baud_end, frame_end;
  logic [DATA_BITS-1:0] head;

  state_t               state;
  logic [CW-1:0]        baud_cnt;
  logic [2:0]           bit_idx;
  logic                 stop_idx;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_bit;

  assign wr_ready      = fifo_count < (AW + 1)'(FIFO_DEPTH);
  assign fifo_nonempty = fifo_count != '0;
  assign push          = wr_valid && wr_ready;
  assign head          = mem[rd_ptr];
  assign baud_end      = baud_cnt == CNT_LAST;
  assign frame_end     = (state == STOP) && baud_end && (stop_idx == STOP_LAST);
  assign pop           = fifo_nonempty && ((state == IDLE) || frame_end);
  assign busy          = state != IDLE;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: ;
      endcase
    end
  end

  // Every state/bit change happens on baud_end, so the counter always restarts at 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      stop_idx <= 1'b0;
      shreg    <= '0;
      par_bit  <= 1'b0;
      txd      <= 1'b1;
    end else begin
      baud_cnt <= baud_end ? '0 : baud_cnt + 1'b1;
      case (state)
        IDLE: begin
          baud_cnt <= '0;
          txd      <= 1'b1;
          if (pop) begin
            state   <= START;
            shreg   <= head;
            par_bit <= (^head) ^ PAR_INV;
            txd     <= 1'b0;
          end
        end
        START: if (baud_end) begin
          state   <= DATA;
          bit_idx <= '0;
          txd     <= shreg[0];
        end
        DATA: if (baud_end) begin
          if (bit_idx == BIT_LAST) begin
            stop_idx <= 1'b0;
            if (HAS_PAR) begin
              state <= PAR;
              txd   <= par_bit;
            end else begin
              state <= STOP;
              txd   <= 1'b1;
            end
          end else begin
            bit_idx <= bit_idx + 1'b1;
            shreg   <= shreg >> 1;
            txd     <= shreg[1];
          end
        end
        PAR: if (baud_end) begin
          state    <= STOP;
          stop_idx <= 1'b0;
          txd      <= 1'b1;
        end
        STOP: if (baud_end) begin
          if (stop_idx == STOP_LAST) begin
            if (pop) begin
              state   <= START;
              shreg   <= head;
              par_bit <= (^head) ^ PAR_INV;
              txd     <= 1'b0;
            end else begin
              state <= IDLE;
              txd   <= 1'b1;
            end
          end else begin
            stop_idx <= stop_idx + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          txd   <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: 8N2, 8E2 and 7O1 instances checked against a frame model and a word scoreboard.
module tb_uart_tx_fifo;
`ifdef UART_TX_FAST_SIM_EN
  localparam int DIV = 1;
`else
  localparam int DIV = 10;
`endif
  localparam int FLEN0 = 11;
  localparam int FLEN_E = 12;
  localparam int FLEN_O = 10;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [7:0] wr_data0 = '0;
  logic       wr_valid0 = 1'b0;
  logic       wr_ready0, txd0, busy0;
  logic [3:0] fifo_count0;

  logic [7:0] wr_data_e = '0;
  logic       wr_valid_e = 1'b0;
  logic       wr_ready_e, txd_e, busy_e;
  logic [3:0] count_e;

  logic [6:0] wr_data_o = '0;
  logic       wr_valid_o = 1'b0;
  logic       wr_ready_o, txd_o, busy_o;
  logic [2:0] count_o;

  uart_tx_fifo #(.CLK_FREQ(1000000), .BAUD(100000), .DATA_BITS(8), .PARITY(0),
                 .STOP_BITS(2), .FIFO_DEPTH(8)) dut0 (
    .clk(clk), .rst(rst), .wr_data(wr_data0), .wr_valid(wr_valid0), .wr_ready(wr_ready0),
    .txd(txd0), .busy(busy0), .fifo_count(fifo_count0));

  uart_tx_fifo #(.CLK_FREQ(1000000), .BAUD(100000), .DATA_BITS(8), .PARITY(1),
                 .STOP_BITS(2), .FIFO_DEPTH(8)) dut_e (
    .clk(clk), .rst(rst), .wr_data(wr_data_e), .wr_valid(wr_valid_e), .wr_ready(wr_ready_e),
    .txd(txd_e), .busy(busy_e), .fifo_count(count_e));

  uart_tx_fifo #(.CLK_FREQ(1000000), .BAUD(100000), .DATA_BITS(7), .PARITY(2),
                 .STOP_BITS(1), .FIFO_DEPTH(4)) dut_o (
    .clk(clk), .rst(rst), .wr_data(wr_data_o), .wr_valid(wr_valid_o), .wr_ready(wr_ready_o),
    .txd(txd_o), .busy(busy_o), .fifo_count(count_o));

  int total = 0;
  int bad = 0;
  logic [7:0] exp_q[$];
  int gap_q[$];
  int gap = 0;
  int frames_seen = 0;
  int acc_count = 0;
  bit mon_en = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Frame = start(0), data LSB first, optional parity, then ones for the stop bits.
  function automatic logic [15:0] model_frame(input logic [7:0] w, input int db, input int par);
    logic [15:0] f;
    int n;
    logic p;
    f = '1;
    f[0] = 1'b0;
    n = 1;
    p = 1'b0;
    for (int i = 0; i < db; i++) begin
      f[n] = w[i];
      p = p ^ w[i];
      n++;
    end
    if (par != 0) f[n] = (par == 2) ? ~p : p;
    return f;
  endfunction

  always @(posedge clk) begin
    if (!rst && wr_valid0 && wr_ready0) begin
      exp_q.push_back(wr_data0);
      acc_count++;
    end
  end

  task automatic check_frame();
    logic [7:0] w;
    logic [15:0] f;
    logic seen;
    gap_q.push_back(gap);
    gap = 0;
    frames_seen++;
    check("frame_expected", exp_q.size() != 0, 1);
    w = (exp_q.size() != 0) ? exp_q.pop_front() : 8'h00;
    f = model_frame(w, 8, 0);
    for (int b = 0; b < FLEN0; b++) begin
      seen = txd0;
      for (int c = 0; c < DIV; c++) begin
        if (txd0 !== f[b]) seen = txd0;
        @(negedge clk);
      end
      check($sformatf("bit%0d_w%02h", b, w), seen, f[b]);
    end
  endtask

  initial begin
    @(negedge clk);
    forever begin
      if (mon_en && !rst && txd0 === 1'b0) check_frame();
      else begin
        if (mon_en && !rst) gap++;
        @(negedge clk);
      end
    end
  end

  task automatic send_one_timed(input logic [7:0] w);
    int n;
    @(posedge clk); #1;
    wr_data0 = w;
    wr_valid0 = 1'b1;
    @(posedge clk); #1;
    wr_valid0 = 1'b0;
    @(negedge clk);
    check("lat_txd_k", txd0, 1);
    check("lat_count_k", fifo_count0, 1);
    @(negedge clk);
    check("lat_txd_k1", txd0, 0);
    check("lat_busy_k1", busy0, 1);
    check("lat_count_k1", fifo_count0, 0);
    n = 0;
    while (busy0 === 1'b1 && n < 4000) begin
      n++;
      @(negedge clk);
    end
    check($sformatf("busy_len_%02h", w), n, FLEN0 * DIV);
  endtask

  task automatic capture(input int which, input logic [7:0] w, input int nb, output logic [15:0] bits);
    bit found;
    logic line;
    int n;
    @(posedge clk); #1;
    if (which == 1) begin wr_data_e = w; wr_valid_e = 1'b1; end
    else begin wr_data_o = w[6:0]; wr_valid_o = 1'b1; end
    @(posedge clk); #1;
    wr_valid_e = 1'b0;
    wr_valid_o = 1'b0;
    bits = '1;
    found = 1'b0;
    for (int t = 0; t < 4 * DIV + 4 && !found; t++) begin
      @(negedge clk);
      line = (which == 1) ? txd_e : txd_o;
      if (line === 1'b0) found = 1'b1;
    end
    check("cap_start", found, 1);
    if (found) begin
      for (int t = 0; t < nb * DIV; t++) begin
        line = (which == 1) ? txd_e : txd_o;
        if (t % DIV == DIV / 2) bits[t / DIV] = line;
        @(negedge clk);
      end
    end
    n = 0;
    while ((busy_e === 1'b1 || busy_o === 1'b1) && n < 4000) begin
      n++;
      @(negedge clk);
    end
    check("cap_idle", {busy_e, busy_o}, 0);
  endtask

  initial begin
    logic [15:0] bits;
    logic [7:0] w;
    bit rdy, rdy_prev, chk_done, hi_ok, found;
    int idx, n, target, gsum;

    // Reset held for three cycles.
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_txd", txd0, 1);
    check("rst_ready", wr_ready0, 1);
    check("rst_busy", busy0, 0);
    check("rst_count", fifo_count0, 0);
    check("rst_txd_par", {txd_e, txd_o, wr_ready_e, wr_ready_o}, 4'hF);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_txd", txd0, 1);
    check("post_rst_count", {count_e, count_o}, 0);
    mon_en = 1'b1;

    send_one_timed(8'h55);
    send_one_timed(8'hA5);

    // Parity frames.
    capture(1, 8'h07, FLEN_E, bits);
    check("even_07_par", bits[9], 1);
    check("even_07_frame", bits, model_frame(8'h07, 8, 1));
    capture(2, 8'h07, FLEN_O, bits);
    check("odd_07_par", bits[8], 0);
    check("odd_07_frame", bits, model_frame(8'h07, 7, 2));
    capture(1, 8'h03, FLEN_E, bits);
    check("even_03_par", bits[9], 0);
    for (int k = 0; k < 3; k++) begin
      w = 8'($urandom);
      capture(1, w, FLEN_E, bits);
      check($sformatf("even_rand_%02h", w), bits, model_frame(w, 8, 1));
      w = 8'($urandom_range(0, 127));
      capture(2, w, FLEN_O, bits);
      check($sformatf("odd_rand_%02h", w), bits, model_frame(w, 7, 2));
    end

    // Backpressure: continuous valid with 0x00..0x0B.
    gap_q.delete();
    frames_seen = 0;
    idx = 0;
    n = 0;
    chk_done = 1'b0;
    @(negedge clk);
    wr_data0 = 8'h00;
    wr_valid0 = 1'b1;
    while (idx < 12 && n < 20000) begin
      rdy = wr_ready0;
      @(posedge clk); #1;
      if (rdy) begin
        idx++;
        wr_data0 = 8'(idx);
      end
      if (idx == 12) wr_valid0 = 1'b0;
      @(negedge clk);
      n++;
      if (idx == 9 && !chk_done) begin
        check("bp_cycles", n, 9);
        check("bp_ready", wr_ready0, 0);
        check("bp_count", fifo_count0, 8);
        chk_done = 1'b1;
      end
    end
    wr_valid0 = 1'b0;
    check("bp_all_accepted", idx, 12);
    n = 0;
    while ((busy0 !== 1'b0 || fifo_count0 !== 4'd0) && n < 20000) begin
      n++;
      @(negedge clk);
    end
    repeat (2) @(negedge clk);
    check("bp_frames", frames_seen, 12);
    check("bp_q_empty", exp_q.size(), 0);
    gsum = 0;
    for (int i = 1; i < gap_q.size(); i++) gsum += gap_q[i];
    check("bp_no_gaps", gsum, 0);

    // Randomised traffic with valid held until accepted.
    target = acc_count + 24;
    rdy_prev = 1'b1;
    n = 0;
    while (n < 20000) begin
      @(negedge clk);
      n++;
      check("ready_vs_count", wr_ready0, fifo_count0 < 4'd8);
      if (!(wr_valid0 && !rdy_prev)) begin
        if (acc_count >= target) begin
          wr_valid0 = 1'b0;
          break;
        end
        wr_valid0 = ($urandom_range(0, 3) != 0);
        wr_data0 = 8'($urandom);
      end
      rdy_prev = wr_ready0;
    end
    wr_valid0 = 1'b0;
    n = 0;
    while ((busy0 !== 1'b0 || fifo_count0 !== 4'd0) && n < 20000) begin
      n++;
      @(negedge clk);
    end
    repeat (2) @(negedge clk);
    check("rand_q_empty", exp_q.size(), 0);
    check("rand_idle_txd", txd0, 1);

    // Reset during data bit 3 with two words queued.
    mon_en = 1'b0;
    @(posedge clk); #1;
    wr_valid0 = 1'b1;
    wr_data0 = 8'hF0;
    @(posedge clk); #1;
    wr_data0 = 8'h11;
    @(posedge clk); #1;
    wr_data0 = 8'h22;
    @(posedge clk); #1;
    wr_valid0 = 1'b0;
    found = 1'b0;
    for (int t = 0; t < 4 * DIV + 4 && !found; t++) begin
      @(negedge clk);
      if (txd0 === 1'b0) found = 1'b1;
    end
    check("mid_start", found, 1);
    repeat (4 * DIV + DIV / 2) @(negedge clk);
    check("mid_bit3", txd0, 0);
    check("mid_queued", fifo_count0, 2);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_txd", txd0, 1);
    check("mid_rst_busy", busy0, 0);
    check("mid_rst_count", fifo_count0, 0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    hi_ok = 1'b1;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (txd0 !== 1'b1 || busy0 !== 1'b0) hi_ok = 1'b0;
    end
    check("mid_quiet_200", hi_ok, 1);
    gap = 0;
    mon_en = 1'b1;
    send_one_timed(8'h3C);
    repeat (2) @(negedge clk);
    check("final_q_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
